// File: rtl/pa_risc_pkg.sv
// Shared constants for the PA-RISC pipeline.
// Register-file geometry and the hard-wired zero register.
package pa_risc_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int NUM_REGS = 32;

endpackage

// File: rtl/wb_register_file_rf_read_port.sv
// One combinational read port of the general register file.
// Forces R0 to zero and forwards same-cycle write-back data.
module rf_read_port
    import pa_risc_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int BYPASS_EN = 1
) (
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic                                  wb_we,
    input  logic [ADDR_W-1:0]                     wb_rd,
    input  logic [DATA_W-1:0]                     wb_data,
    output logic [DATA_W-1:0]                     data
);

    logic hit;

    assign hit = (BYPASS_EN != 0) && wb_we && (addr == wb_rd);

    always_comb begin
        data = regs[addr];
        if (hit) begin
            data = wb_data;
        end
        // R0 wins over any forwarding, even a stray bypass
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// PA-RISC general register file: one WB write port, three ID read ports.
// Same-cycle write-back is optionally forwarded to every read port.
module wb_register_file
    import pa_risc_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] WB_PD_in,
    input  logic [ADDR_W-1:0] WB_RD_in,
    input  logic              WB_RF_LE_in,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RD_rd,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    output logic [15:0]       wr_count
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic                         wb_we;

    // Gating with Reset keeps the bypass from leaking data while held in reset
    assign wb_we = WB_RF_LE_in
                && (WB_RD_in != ADDR_W'(REG_ZERO))
                && Reset;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            regs     <= '0;
            wr_count <= '0;
        end else if (wb_we) begin
            regs[WB_RD_in] <= WB_PD_in;
            wr_count       <= wr_count + 16'd1;
        end
    end

    rf_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_port_a (
        .addr    (RA),
        .regs    (regs),
        .wb_we   (wb_we),
        .wb_rd   (WB_RD_in),
        .wb_data (WB_PD_in),
        .data    (PA)
    );

    rf_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_port_b (
        .addr    (RB),
        .regs    (regs),
        .wb_we   (wb_we),
        .wb_rd   (WB_RD_in),
        .wb_data (WB_PD_in),
        .data    (PB)
    );

    rf_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_port_d (
        .addr    (RD_rd),
        .regs    (regs),
        .wb_we   (wb_we),
        .wb_rd   (WB_RD_in),
        .wb_data (WB_PD_in),
        .data    (PD)
    );

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: bypassing and non-bypassing copies
// driven in lockstep and checked against an array-based model.
module tb_wb_register_file;

    logic        clk;
    logic        Reset;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        le;
    logic [4:0]  ra, rb, rdr;

    logic [31:0] pa1, pb1, pd1, pa0, pb0, pd0;
    logic [15:0] cnt1, cnt0;

    logic [31:0] m [32];
    logic [15:0] mcnt;

    int compared = 0;
    int mismatched = 0;

    wb_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1)) u_byp (
        .clk         (clk),
        .Reset       (Reset),
        .WB_PD_in    (wd),
        .WB_RD_in    (rd),
        .WB_RF_LE_in (le),
        .RA          (ra),
        .RB          (rb),
        .RD_rd       (rdr),
        .PA          (pa1),
        .PB          (pb1),
        .PD          (pd1),
        .wr_count    (cnt1)
    );

    wb_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(0)) u_nob (
        .clk         (clk),
        .Reset       (Reset),
        .WB_PD_in    (wd),
        .WB_RD_in    (rd),
        .WB_RF_LE_in (le),
        .RA          (ra),
        .RB          (rb),
        .RD_rd       (rdr),
        .PA          (pa0),
        .PB          (pb0),
        .PD          (pd0),
        .wr_count    (cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = '0;
        mcnt = '0;
    endtask

    // Expected read: R0 is zero, a live same-cycle write forwards when enabled
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && Reset === 1'b1 && le === 1'b1 && rd !== 5'd0 && a === rd)
            return wd;
        return m[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        chk({tag, " pa byp"}, pa1, exp_rd(ra, 1'b1));
        chk({tag, " pb byp"}, pb1, exp_rd(rb, 1'b1));
        chk({tag, " pd byp"}, pd1, exp_rd(rdr, 1'b1));
        chk({tag, " pa nob"}, pa0, exp_rd(ra, 1'b0));
        chk({tag, " pb nob"}, pb0, exp_rd(rb, 1'b0));
        chk({tag, " pd nob"}, pd0, exp_rd(rdr, 1'b0));
        chk({tag, " cnt byp"}, {16'd0, cnt1}, {16'd0, mcnt});
        chk({tag, " cnt nob"}, {16'd0, cnt0}, {16'd0, mcnt});
    endtask

    task automatic tick();
        @(posedge clk);
        if (Reset === 1'b1 && le === 1'b1 && rd !== 5'd0) begin
            m[rd] = wd;
            mcnt  = mcnt + 16'd1;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        le = 1'b1;
        rd = r;
        wd = d;
        tick();
        le = 1'b0;
    endtask

    initial begin
        logic [15:0] c0;
        Reset = 1'b0;
        le = 1'b0;
        rd = '0;
        wd = '0;
        ra = '0;
        rb = '0;
        rdr = '0;
        model_clear();
        #3;
        ra = 5'd3;
        rb = 5'd17;
        rdr = 5'd31;
        #1 check("reset");
        @(posedge clk);
        #1 Reset = 1'b1;

        // basic write then read
        wr(5'd7, 32'hDEADBEEF);
        ra = 5'd7;
        #1 check("basic");
        chk("basic pa const", pa1, 32'hDEADBEEF);
        chk("basic cnt const", {16'd0, cnt1}, 32'd1);

        // asynchronous reset mid-cycle
        wr(5'd5, 32'h12345678);
        ra = 5'd5;
        rb = 5'd5;
        rdr = 5'd5;
        #1 check("r5 written");
        #2 Reset = 1'b0;
        model_clear();
        #1 check("async rst");
        chk("async rst pa const", pa1, 32'd0);
        chk("async rst cnt const", {16'd0, cnt1}, 32'd0);
        @(posedge clk);
        #1 Reset = 1'b1;

        // writes to R0 are discarded
        c0 = mcnt;
        le = 1'b1;
        rd = 5'd0;
        wd = 32'hFFFFFFFF;
        ra = 5'd0;
        rb = 5'd0;
        rdr = 5'd0;
        #1 check("r0 same");
        tick();
        le = 1'b0;
        #1 check("r0 next");
        chk("r0 cnt", {16'd0, cnt1}, {16'd0, c0});

        // bypass versus stored-only
        wr(5'd3, 32'h11111111);
        wr(5'd4, 32'h44444444);
        le = 1'b1;
        rd = 5'd3;
        wd = 32'h22222222;
        ra = 5'd3;
        rb = 5'd3;
        rdr = 5'd4;
        #1 check("bypass same");
        chk("bypass pa const", pa1, 32'h22222222);
        chk("bypass pd const", pd1, 32'h44444444);
        chk("nobyp pa const", pa0, 32'h11111111);
        tick();
        le = 1'b0;
        #1 check("bypass next");
        chk("nobyp next const", pa0, 32'h22222222);

        // back-to-back writes to the same register
        c0 = mcnt;
        wr(5'd9, 32'hA);
        wr(5'd9, 32'hB);
        wr(5'd9, 32'hC);
        ra = 5'd9;
        #1 check("b2b");
        chk("b2b pa const", pa0, 32'hC);
        chk("b2b cnt delta", {16'd0, cnt1 - c0}, 32'd3);

        // X destination with load enable low
        le = 1'b0;
        rd = 'x;
        wd = 32'h0BADF00D;
        tick();
        rd = 5'd0;
        #1 check("x dest");

        // reset coincident with a write
        le = 1'b1;
        rd = 5'd10;
        wd = 32'h55555555;
        Reset = 1'b0;
        model_clear();
        tick();
        le = 1'b0;
        ra = 5'd10;
        #1 check("rst+wr held");
        Reset = 1'b1;
        #1 check("rst+wr rel");
        chk("rst+wr r10 const", pa0, 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            le = 1'($urandom_range(0, 2) != 0);
            rd = 5'($urandom);
            wd = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            rdr = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            Reset = 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b0;
                model_clear();
            end
            #1 check("rand");
            tick();
        end
        Reset = 1'b1;
        le = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            rdr = 5'(i);
            #1 check("sweep");
        end

        // counter wrap
        Reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1 Reset = 1'b1;
        le = 1'b1;
        rd = 5'd1;
        for (int i = 0; i < 65535; i++) begin
            wd = i;
            tick();
        end
        le = 1'b0;
        #1 chk("wrap pre", {16'd0, cnt1}, 32'h0000FFFF);
        wr(5'd1, 32'hCAFEF00D);
        ra = 5'd1;
        #1 check("wrap");
        chk("wrap cnt const", {16'd0, cnt0}, 32'd0);
        chk("wrap r1 const", pa0, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- 32 x 32-bit general register file for the PA-RISC pipeline.
- Single write port is the write-back end of the MEM/WB stage register: it consumes the write-back data, destination and load-enable values that the MEM/WB register holds.
- Three read ports serve the ID stage: operand A, operand B, and store data.
- Same-cycle write-back is bypassed to the read ports, so ID never sees stale data from an in-flight WB write.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers.
- BYPASS_EN, 1, 1 = WB-to-ID internal forwarding enabled; 0 = reads return stored contents only.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset; asserted when 0.
- WB_PD_in  in  DATA_W  write-back data from the MEM/WB stage.
- WB_RD_in  in  ADDR_W  write-back destination register.
- WB_RF_LE_in  in  1  register-file load enable from the MEM/WB stage.
- RA  in  ADDR_W  read address, port A.
- RB  in  ADDR_W  read address, port B.
- RD_rd  in  ADDR_W  read address, store-data port.
- PA  out  DATA_W  port A data.
- PB  out  DATA_W  port B data.
- PD  out  DATA_W  store-data port data.
- wr_count  out  16  number of committed writes since reset, for debug.

Behaviour:
- Reset:
  - Reset=0 immediately clears all registers R0..R31 and wr_count to 0, regardless of clk.
  - While Reset=0, writes are ignored and PA/PB/PD read 0.
  - Deassertion is sampled at the next rising edge of clk; the first write can commit on that edge.
- Write:
  - At the rising edge of clk, if WB_RF_LE_in=1 and WB_RD_in!=0, then R[WB_RD_in] <= WB_PD_in and wr_count increments by 1.
  - Write latency is 1 cycle: the stored value is visible from the next cycle.
- R0:
  - Hard-wired zero and never stored.
  - A write to R0 is discarded and does not increment wr_count.
  - Any read of address 0 returns 0, including when a bypass targets R0.
- Read:
  - Combinational, zero latency: PA = R[RA], PB = R[RB], PD = R[RD_rd].
- Bypass (BYPASS_EN=1):
  - If WB_RF_LE_in=1, WB_RD_in!=0, and a read address equals WB_RD_in, that port returns WB_PD_in in the same cycle.
  - Each port is evaluated independently; any or all three may bypass at once.
  - BYPASS_EN=0: ports return stored contents only, so the new value appears one cycle later.
- Boundary conditions:
  - Back-to-back writes to the same register: the last write wins; each write counts.
  - wr_count wraps 0xFFFF -> 0x0000 with no flag.
  - Reset asserted in the same cycle as a write: reset wins; the register stays 0 and wr_count stays 0.
  - X or unknown WB_RD_in while WB_RF_LE_in=0: no state change.

Decomposition:
- Shared package pa_risc_pkg holds:
  - the DATA_W/ADDR_W defaults;
  - the constant REG_ZERO = 5'd0;
  - the constant NUM_REGS = 32.
- One natural sub-module: rf_read_port (address in, storage array, WB write signals in, data out).
  - Instantiated three times.
  - Encapsulates the R0 forcing and the bypass compare.
- The write decoder and storage array stay in the top module.

Test Plan:
- Reset check: drive Reset=0 mid-run after R5=0x12345678 has been written -> PA/PB/PD with RA=5 read 0 immediately (asynchronously), and wr_count=0.
- Basic write/read: LE=1, RD=7, PD=0xDEADBEEF for one cycle, then LE=0; RA=7 the next cycle -> PA=0xDEADBEEF; wr_count=1.
- R0 protection: LE=1, RD=0, PD=0xFFFFFFFF; RA=RB=RD_rd=0 -> all three outputs read 0 both in the same and the next cycle; wr_count unchanged.
- Bypass: R3=0x11111111 stored; same cycle LE=1, RD=3, PD=0x22222222 with RA=3, RB=3, RD_rd=4:
  - BYPASS_EN=1 -> PA=PB=0x22222222 combinationally, and PD reads R4.
  - BYPASS_EN=0 -> PA=0x11111111 that cycle and 0x22222222 the next.
- Back-to-back writes and simultaneous reset:
  - Writes to R9 of 0xA, then 0xB, then 0xC on consecutive cycles -> R9=0xC and wr_count=3.
  - Reset asserted coincident with a write to R10 -> R10=0.
- Counter wrap: preload wr_count to 0xFFFF via 65535 writes to R1, then one more write -> wr_count=0x0000 and R1 holds the last data.
